mem_xfer_seq: RTL
=================

Name: mem_xfer_seq

Overview:
- Parametrised load/store transfer sequencer between the MEMORY block and the DATAPATH register file.
- Moves a burst of 1..MAX_BURST consecutive words in either direction, memory→registers (load) or registers→memory (store), and generates all read, write and select strobes itself.
- Sits beside the control unit: the control unit issues one start command and waits for done.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 8, memory address width.
- REG_AW, 4, register file address width.
- MAX_BURST, 4, largest word count per command.
- MEM_LAT, 1, memory read latency in cycles (≥1).

Ports:
- CLK100MHZ  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  command strobe, sampled in IDLE only.
- op  in  1  0 = load (mem→reg), 1 = store (reg→mem).
- mem_base  in  ADDR_W  first memory address.
- reg_base  in  REG_AW  first register.
- count  in  clog2(MAX_BURST+1)  words to move.
- busy  out  1  high while a command is executing.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle rejection pulse.
- mem_sel  out  1  memory address mux select; 1 = sequencer address.
- mem_addr  out  ADDR_W  memory address.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- rf_sel  out  1  datapath write mux select; 1 = memory data.
- rf_waddr  out  REG_AW  register write address.
- rf_write  out  1  register write strobe.
- rf_wdata  out  DATA_W  register write data.
- rf_raddr  out  REG_AW  register read address (port A).
- rf_read  out  1  register read strobe.
- rf_rdata  in  DATA_W  register port A data; valid the cycle after rf_read.

Behaviour:
- Reset: every output is 0, the state machine is IDLE, and the internal counters and holding register are 0. Assertion mid-command takes effect immediately (asynchronous). No further strobes are issued, and the command is abandoned without done or error.
- States: IDLE, LD_REQ, LD_WB, ST_RD, ST_WR, FIN, ERR.
- IDLE: start=1 latches op, mem_base, reg_base and count into working registers.
  - If count==0, count>MAX_BURST, or reg_base+count > 2^REG_AW: go to ERR.
  - Otherwise go to LD_REQ (op=0) or ST_RD (op=1).
- start is ignored outside IDLE. Inputs other than rf_rdata and mem_rdata are don't-care after the latch cycle.
- busy = 1 in LD_REQ, LD_WB, ST_RD, ST_WR and FIN. busy = 0 in IDLE and ERR.
- mem_sel = busy. rf_sel = 1 only in LD_WB.
- LD_REQ: held for exactly MEM_LAT cycles, using an internal latency counter.
  - mem_read=1 and mem_addr=current address for the whole state.
  - mem_rdata is captured into the holding register on the edge that ends the last LD_REQ cycle.
- LD_WB: one cycle, with rf_write=1, rf_waddr=current register, rf_wdata=holding register.
  - On exit the address and register increment and the remaining count decrements.
  - Go to LD_REQ if words remain, else FIN.
- Load throughput: MEM_LAT+1 cycles per word.
- ST_RD: one cycle, with rf_read=1 and rf_raddr=current register.
- ST_WR: one cycle, with mem_write=1, mem_addr=current address and mem_wdata=rf_rdata (combinational pass-through).
  - Then increment, decrement, and loop to ST_RD or go to FIN.
- Store throughput: 2 cycles per word.
- FIN: one cycle, done=1, busy=1, then IDLE. A start presented during FIN is ignored.
- ERR: one cycle, error=1, no memory or register strobe, then IDLE.
- Memory address increments modulo 2^ADDR_W, so it wraps (0xFF→0x00 at the default width). The register range never wraps; this is guaranteed by the ERR check.
- At most one strobe among mem_read, mem_write, rf_write and rf_read is high in any cycle.
- Strobes, addresses and data are registered outputs, except mem_wdata, which is combinational from rf_rdata.

Test Plan:
1. Reset, then start with op=0, mem_base=0xFF, reg_base=0, count=1, where mem[0xFF]=0xBEEF.
   - Required: one cycle of mem_read@0xFF, then rf_write to r0 with 0xBEEF.
   - Required: done pulses 3 cycles after start, and busy is high for 3 cycles.
2. Store with op=1, reg_base=2, mem_base=0xFE, count=3, where r2..r4 = 0x1111/0x2222/0x3333.
   - Required: mem[0xFE]=0x1111, mem[0xFF]=0x2222, mem[0x00]=0x3333 (wrap), with 6 busy cycles before FIN.
3. Error cases, each giving one error pulse, no strobes and busy=0:
   - count=0.
   - count=5.
   - reg_base=14 with count=3.
4. MEM_LAT=3 instance: load with count=2 from 0x10.
   - Required: mem_read is high for 3 consecutive cycles per word, rf_write fires twice, and total busy is 8 cycles plus FIN.
5. Assert RST during the second ST_WR of a count=4 store.
   - Required: outputs drop to 0 asynchronously, only the first word is written, and neither done nor error pulses.
6. Start held high continuously across a count=2 load.
   - Required: a second command is accepted only after the sequencer returns to IDLE (the cycle after FIN), never during busy or FIN.

Source files
------------

// File: rtl/mem_xfer_seq.sv
// -----------------------------------------------------------------------------
// mem_xfer_seq
//
// Load/store burst sequencer between the memory block and the datapath
// register file. One start command moves 1..MAX_BURST consecutive words either
// memory -> registers (load, op=0) or registers -> memory (store, op=1). The
// control unit issues start and waits for done (or error on a bad command).
//
// Ports
//   CLK100MHZ  system clock, rising edge
//   RST        asynchronous active-high reset
//   start      command strobe, sampled only in IDLE
//   op         0 = load, 1 = store
//   mem_base   first memory address
//   reg_base   first register
//   count      number of words to move
//   busy       high while a command executes (including the FIN cycle)
//   done       one-cycle completion pulse
//   error      one-cycle rejection pulse
//   mem_sel    memory address mux select (1 = sequencer address)
//   mem_addr   memory address
//   mem_read   memory read strobe
//   mem_write  memory write strobe
//   mem_wdata  memory write data (combinational from rf_rdata)
//   mem_rdata  memory read data, valid MEM_LAT cycles into a read
//   rf_sel     register write mux select (1 = memory data)
//   rf_waddr   register write address
//   rf_write   register write strobe
//   rf_wdata   register write data
//   rf_raddr   register read address (port A)
//   rf_read    register read strobe
//   rf_rdata   register port A data, valid the cycle after rf_read
// -----------------------------------------------------------------------------
module mem_xfer_seq #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 8,
   parameter int REG_AW    = 4,
   parameter int MAX_BURST = 4,
   parameter int MEM_LAT   = 1,
   localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
   input  logic              CLK100MHZ,
   input  logic              RST,
   input  logic              start,
   input  logic              op,
   input  logic [ADDR_W-1:0] mem_base,
   input  logic [REG_AW-1:0] reg_base,
   input  logic [CNT_W-1:0]  count,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              mem_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rf_sel,
   output logic [REG_AW-1:0] rf_waddr,
   output logic              rf_write,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [REG_AW-1:0] rf_raddr,
   output logic              rf_read,
   input  logic [DATA_W-1:0] rf_rdata
);

   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int SUM_W = REG_AW + CNT_W + 1;

   localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_BURST);
   localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MEM_LAT - 1);
   localparam logic [SUM_W-1:0] REG_LIMIT = SUM_W'(1) << REG_AW;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_REQ,
      S_LD_WB,
      S_ST_RD,
      S_ST_WR,
      S_FIN,
      S_ERR
   } state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [REG_AW-1:0]   rreg_reg, rreg_next;
   logic [CNT_W-1:0]    rem_reg, rem_next;
   logic [LAT_W-1:0]    lat_reg, lat_next;
   logic [DATA_W-1:0]   hold_reg, hold_next;

   logic                busy_reg, busy_next;
   logic                done_reg, done_next;
   logic                error_reg, error_next;
   logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
   logic                mem_read_reg, mem_read_next;
   logic                mem_write_reg, mem_write_next;
   logic                rf_sel_reg, rf_sel_next;
   logic [REG_AW-1:0]   rf_waddr_reg, rf_waddr_next;
   logic                rf_write_reg, rf_write_next;
   logic [DATA_W-1:0]   rf_wdata_reg, rf_wdata_next;
   logic [REG_AW-1:0]   rf_raddr_reg, rf_raddr_next;
   logic                rf_read_reg, rf_read_next;

   // Command validity: the register range must fit without wrapping, so the
   // end index is computed one bit wider than any operand can reach.
   logic [SUM_W-1:0]    reg_end;
   logic                bad_cmd;

   assign reg_end = SUM_W'(reg_base) + SUM_W'(count);
   assign bad_cmd = (count == '0) || (count > MAX_CNT) || (reg_end > REG_LIMIT);

   // Next-state logic first, then the output strobes are decoded from the
   // next state so every strobe/address/data output comes straight from a flop.
   always_comb begin
      state_next     = state_reg;
      addr_next      = addr_reg;
      rreg_next      = rreg_reg;
      rem_next       = rem_reg;
      lat_next       = lat_reg;
      hold_next      = hold_reg;

      busy_next      = 1'b0;
      done_next      = 1'b0;
      error_next     = 1'b0;
      mem_addr_next  = '0;
      mem_read_next  = 1'b0;
      mem_write_next = 1'b0;
      rf_sel_next    = 1'b0;
      rf_waddr_next  = '0;
      rf_write_next  = 1'b0;
      rf_wdata_next  = '0;
      rf_raddr_next  = '0;
      rf_read_next   = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               addr_next = mem_base;
               rreg_next = reg_base;
               rem_next  = count;
               lat_next  = '0;
               if (bad_cmd) begin
                  state_next = S_ERR;
               end else if (op) begin
                  state_next = S_ST_RD;
               end else begin
                  state_next = S_LD_REQ;
               end
            end
         end
         S_LD_REQ: begin
            // Read data is taken on the edge closing the last request cycle.
            if (lat_reg == LAT_LAST) begin
               hold_next  = mem_rdata;
               lat_next   = '0;
               state_next = S_LD_WB;
            end else begin
               lat_next = lat_reg + LAT_W'(1);
            end
         end
         S_LD_WB, S_ST_WR: begin
            // Memory address wraps naturally; the register index cannot
            // overrun because such commands were rejected up front.
            addr_next = addr_reg + ADDR_W'(1);
            rreg_next = rreg_reg + REG_AW'(1);
            rem_next  = rem_reg - CNT_W'(1);
            if (rem_reg == CNT_W'(1)) begin
               state_next = S_FIN;
            end else if (state_reg == S_LD_WB) begin
               state_next = S_LD_REQ;
            end else begin
               state_next = S_ST_RD;
            end
         end
         S_ST_RD: begin
            state_next = S_ST_WR;
         end
         S_FIN, S_ERR: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      case (state_next)
         S_LD_REQ: begin
            busy_next     = 1'b1;
            mem_read_next = 1'b1;
            mem_addr_next = addr_next;
         end
         S_LD_WB: begin
            busy_next     = 1'b1;
            rf_sel_next   = 1'b1;
            rf_write_next = 1'b1;
            rf_waddr_next = rreg_next;
            rf_wdata_next = hold_next;
         end
         S_ST_RD: begin
            busy_next     = 1'b1;
            rf_read_next  = 1'b1;
            rf_raddr_next = rreg_next;
         end
         S_ST_WR: begin
            busy_next      = 1'b1;
            mem_write_next = 1'b1;
            mem_addr_next  = addr_next;
         end
         S_FIN: begin
            busy_next = 1'b1;
            done_next = 1'b1;
         end
         S_ERR: begin
            error_next = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge CLK100MHZ or posedge RST) begin
      if (RST) begin
         state_reg     <= S_IDLE;
         addr_reg      <= '0;
         rreg_reg      <= '0;
         rem_reg       <= '0;
         lat_reg       <= '0;
         hold_reg      <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         error_reg     <= 1'b0;
         mem_addr_reg  <= '0;
         mem_read_reg  <= 1'b0;
         mem_write_reg <= 1'b0;
         rf_sel_reg    <= 1'b0;
         rf_waddr_reg  <= '0;
         rf_write_reg  <= 1'b0;
         rf_wdata_reg  <= '0;
         rf_raddr_reg  <= '0;
         rf_read_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         addr_reg      <= addr_next;
         rreg_reg      <= rreg_next;
         rem_reg       <= rem_next;
         lat_reg       <= lat_next;
         hold_reg      <= hold_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         error_reg     <= error_next;
         mem_addr_reg  <= mem_addr_next;
         mem_read_reg  <= mem_read_next;
         mem_write_reg <= mem_write_next;
         rf_sel_reg    <= rf_sel_next;
         rf_waddr_reg  <= rf_waddr_next;
         rf_write_reg  <= rf_write_next;
         rf_wdata_reg  <= rf_wdata_next;
         rf_raddr_reg  <= rf_raddr_next;
         rf_read_reg   <= rf_read_next;
      end
   end

   assign busy      = busy_reg;
   assign done      = done_reg;
   assign error     = error_reg;
   assign mem_sel   = busy_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_read  = mem_read_reg;
   assign mem_write = mem_write_reg;
   // Pass-through of register port A data, gated so the bus is quiet (and
   // zero in reset) whenever no store write is in progress.
   assign mem_wdata = mem_write_reg ? rf_rdata : '0;
   assign rf_sel    = rf_sel_reg;
   assign rf_waddr  = rf_waddr_reg;
   assign rf_write  = rf_write_reg;
   assign rf_wdata  = rf_wdata_reg;
   assign rf_raddr  = rf_raddr_reg;
   assign rf_read   = rf_read_reg;

endmodule
